// File: rtl/sw_debounce_pkg.sv
// Shared board-I/O constants and helpers for the switch debouncer and its neighbours.
package sw_debounce_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    // Bits needed to count 0..stable_cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = 1;
        while ((1 << w) < stable_cycles) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchroniser, stability counter and registered edge pulses.
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic slowclk_i,
    input  logic rst_i,
    input  logic sw_raw_i,
    output logic sw_db_o,
    output logic sw_rise_o,
    output logic sw_fall_o
);

    localparam int              CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_last;
    db_state_e              state;

    assign s_last = sync_q[SYNC_STAGES-1];

    // Any mismatch between the synchronised level and the accepted level is a
    // pending change; it is accepted only after surviving STABLE_CYCLES edges.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw_i};
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        state  = (s_last != db_q) ? DB_PENDING : DB_IDLE;

        unique case (state)
            DB_IDLE: begin
                cnt_d = '0;
            end
            DB_PENDING: begin
                if (cnt_q == CNT_MAX) begin
                    db_d   = s_last;
                    rise_d = s_last;
                    fall_d = ~s_last;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge slowclk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_db_o   = db_q;
    assign sw_rise_o = rise_q;
    assign sw_fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounced switch bus feeding the slowclk counter/LED block; one channel per switch bit.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             slowclk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_db_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             any_change_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sw_debounce_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .slowclk_i (slowclk_i),
            .rst_i     (rst_i),
            .sw_raw_i  (sw_raw_i[i]),
            .sw_db_o   (sw_db_o[i]),
            .sw_rise_o (sw_rise_o[i]),
            .sw_fall_o (sw_fall_o[i])
        );
    end

    // Pulses are already registered, so this OR lands in the same cycle as them.
    assign any_change_o = |(sw_rise_o | sw_fall_o);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios with pinned literals, then random traffic against a window model.
module tb_sw_debounce;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int SC = 4;

    logic         slowclk;
    logic         rst;
    logic [W-1:0] swRaw;
    logic [W-1:0] swDb, swRise, swFall;
    logic         anyChange;

    int vectors;
    int miscompares;
    int cycle;
    int riseCnt [W];
    int fallCnt [W];
    int anyCnt;

    // Model: raw level reaches the last sync stage S edges later; a bit flips
    // once the last SC observed levels all disagree with the accepted level.
    logic [W-1:0] mSync [S];
    logic [W-1:0] mHist [SC];
    logic [W-1:0] mDb, mRise, mFall;

    sw_debounce #(.WIDTH(W), .SYNC_STAGES(S), .STABLE_CYCLES(SC)) dut (
        .slowclk_i    (slowclk),
        .rst_i        (rst),
        .sw_raw_i     (swRaw),
        .sw_db_o      (swDb),
        .sw_rise_o    (swRise),
        .sw_fall_o    (swFall),
        .any_change_o (anyChange)
    );

    initial slowclk = 1'b0;
    always #5 slowclk = ~slowclk;

    task automatic modelStep(input logic r, input logic [W-1:0] raw);
        logic [W-1:0] sPrev;
        logic         allDiff;
        if (r) begin
            for (int i = 0; i < S; i++) mSync[i] = '0;
            for (int i = 0; i < SC; i++) mHist[i] = '0;
            mDb   = '0;
            mRise = '0;
            mFall = '0;
        end else begin
            sPrev = mSync[S-1];
            for (int i = S - 1; i > 0; i--) mSync[i] = mSync[i-1];
            mSync[0] = raw;
            for (int i = SC - 1; i > 0; i--) mHist[i] = mHist[i-1];
            mHist[0] = sPrev;
            mRise = '0;
            mFall = '0;
            for (int b = 0; b < W; b++) begin
                allDiff = 1'b1;
                for (int k = 0; k < SC; k++) begin
                    if (mHist[k][b] == mDb[b]) allDiff = 1'b0;
                end
                if (allDiff) begin
                    if (sPrev[b]) mRise[b] = 1'b1;
                    else          mFall[b] = 1'b1;
                    mDb[b] = sPrev[b];
                end
            end
        end
    endtask

    task automatic compareVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic checkOutput();
        compareVal("model_sw_db",      swDb,   mDb);
        compareVal("model_sw_rise",    swRise, mRise);
        compareVal("model_sw_fall",    swFall, mFall);
        compareVal("model_any_change", {7'b0, anyChange}, {7'b0, |(mRise | mFall)});
        compareVal("rise_fall_overlap", swRise & swFall, '0);
    endtask

    task automatic clearCounts();
        for (int b = 0; b < W; b++) begin
            riseCnt[b] = 0;
            fallCnt[b] = 0;
        end
        anyCnt = 0;
    endtask

    task automatic applyStimulus(input logic r, input logic [W-1:0] raw);
        rst   = r;
        swRaw = raw;
        @(posedge slowclk);
        #1;
        cycle++;
        modelStep(r, raw);
        checkOutput();
        for (int b = 0; b < W; b++) begin
            if (swRise[b] === 1'b1) riseCnt[b]++;
            if (swFall[b] === 1'b1) fallCnt[b]++;
        end
        if (anyChange === 1'b1) anyCnt++;
    endtask

    task automatic holdRaw(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, raw);
    endtask

    initial begin
        logic [W-1:0] rnd;
        logic         rr;
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        rst         = 1'b1;
        swRaw       = '0;
        mDb = '0; mRise = '0; mFall = '0;
        for (int i = 0; i < S; i++) mSync[i] = '0;
        for (int i = 0; i < SC; i++) mHist[i] = '0;
        clearCounts();

        // Reset with all switches high, then the first full settle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hFF);
            compareVal("rst_db",   swDb,   8'h00);
            compareVal("rst_rise", swRise, 8'h00);
        end
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 8'hFF);
            if (i < 6) compareVal("post_rst_db", swDb, 8'h00);
            if (i == 1) compareVal("post_rst_rise", swRise, 8'h00);
            if (i == 6) begin
                compareVal("settle_db",   swDb,   8'hFF);
                compareVal("settle_rise", swRise, 8'hFF);
            end
            if (i == 7) compareVal("settle_rise_once", swRise, 8'h00);
        end

        // Clean step 00 -> 05.
        holdRaw(8'h00, 8);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 8'h05);
            if (i < 6) compareVal("step_db_hold", swDb, 8'h00);
            if (i == 6) begin
                compareVal("step_db",   swDb,   8'h05);
                compareVal("step_rise", swRise, 8'h05);
                compareVal("step_fall", swFall, 8'h00);
                compareVal("step_any",  {7'b0, anyChange}, 8'h01);
            end
        end

        // Three-cycle glitch on bit 3 is rejected.
        holdRaw(8'h00, 8);
        clearCounts();
        holdRaw(8'h08, 3);
        holdRaw(8'h00, 8);
        compareVal("glitch_rise_cnt", 8'(riseCnt[3]), 8'd0);
        compareVal("glitch_db",       swDb,            8'h00);

        // Four-cycle pulse on bit 3 is accepted, then released.
        clearCounts();
        holdRaw(8'h08, 4);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 8'h00);
            if (i == 2) compareVal("pulse4_rise", swRise, 8'h08);
            if (i == 6) compareVal("pulse4_fall", swFall, 8'h08);
        end
        compareVal("pulse4_rise_cnt", 8'(riseCnt[3]), 8'd1);
        compareVal("pulse4_fall_cnt", 8'(fallCnt[3]), 8'd1);

        // Bouncing rising edge on bit 7.
        clearCounts();
        applyStimulus(1'b0, 8'h80);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h80);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h80);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 8'h80);
            if (i == 5) compareVal("bounce_rise", swRise, 8'h80);
        end
        compareVal("bounce_rise_cnt", 8'(riseCnt[7]), 8'd1);

        // Simultaneous mixed edges F0 -> 0F.
        holdRaw(8'hF0, 10);
        clearCounts();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 8'h0F);
            if (i == 6) begin
                compareVal("mixed_rise", swRise, 8'h0F);
                compareVal("mixed_fall", swFall, 8'hF0);
                compareVal("mixed_any",  {7'b0, anyChange}, 8'h01);
            end
        end
        compareVal("mixed_any_cnt", 8'(anyCnt), 8'd1);

        // Reset while bit 0 is part-way through its count.
        holdRaw(8'h00, 10);
        holdRaw(8'h01, 4);
        applyStimulus(1'b1, 8'h01);
        compareVal("midrst_db", swDb, 8'h00);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 8'h01);
            if (i < 6) begin
                compareVal("midrst_db_hold",  swDb,   8'h00);
                compareVal("midrst_no_pulse", swRise, 8'h00);
            end
            if (i == 6) begin
                compareVal("midrst_db_set", swDb,   8'h01);
                compareVal("midrst_rise",   swRise, 8'h01);
            end
        end

        // Random traffic with frequent flips and occasional resets.
        rnd = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) rnd = rnd ^ 8'($urandom);
            applyStimulus(rr, rnd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
